wb_burst_master: RTL and testbench
==================================

# wb_burst_master

Wishbone B3 initiator that turns single-entry commands (address, beat count, direction, byte selects) into classic or incrementing-burst bus cycles. It drives the same instruction/data bus signal set that the OR1200 exposes. It is instantiated in the verification environment as a second bus master: it preloads and inspects memory models and exercises slave ack/err/rty handling without a CPU. It handles retry back-off, error abort and an optional no-response watchdog.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width (byte selects = `DW/8`)
- `RETRY_MAX`, 4, maximum `rty` responses tolerated per beat
- `TIMEOUT_CYC`, 256, watchdog limit in cycles (used only with `WB_MASTER_TIMEOUT_EN`)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_adr`  in  AW  start byte address; bits [1:0] are ignored and forced to 0
- `cmd_len`  in  4  beats minus 1 (0..15)
- `cmd_sel`  in  DW/8  byte selects, applied to every beat
- `wr_valid` / `wr_ready`  in/out  1  write-data handshake, one transfer per beat
- `wr_data`  in  DW  write beat data
- `rd_valid`  out  1  one-cycle pulse per acked read beat
- `rd_data`  out  DW  read beat data
- `done`  out  1  one-cycle command completion pulse
- `status`  out  2  00 ok, 01 err, 10 retries exhausted, 11 timeout; valid when `done` is high
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  bus cycle, strobe, write enable
- `wb_adr_o`  out  AW  bus address
- `wb_dat_o`  out  DW  bus write data
- `wb_sel_o`  out  DW/8  bus byte selects
- `wb_cti_o`  out  3  cycle type identifier
- `wb_bte_o`  out  2  burst type extension
- `wb_dat_i`  in  DW  bus read data
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1  slave termination

## Operation
- **States:** IDLE, WDATA, BUS, BACKOFF, DONE. All bus outputs are registered.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`, latch the command and the beat counter = `cmd_len`.
  - Write commands go to WDATA.
  - Read commands go to BUS.
- **WDATA:**
  - `wr_ready`=1; `wb_cyc_o` stays high if a burst is already in progress; `wb_stb_o`=0.
  - On `wr_valid`, capture `wr_data` and go to BUS.
- **BUS:** `cyc`=`stb`=1. The slave terminates the beat with one of:
  - **ack:** address += 4 (wraps modulo 2^AW); the retry counter clears.
    - Last beat: go to DONE with `status`=00.
    - Otherwise a write returns to WDATA and a read stays in BUS with the next address.
  - **err:** abort with `status`=01. Remaining beats are not issued.
  - **rty:** go to BACKOFF. If this beat's retry count already equals `RETRY_MAX`, go to DONE with `status`=10 instead.
- **BACKOFF:** `cyc`=`stb`=0 for exactly one cycle, then reissue the same beat (same address and data).
- **Simultaneous terminations:** priority is err > rty > ack.
- **DONE:** `cyc`=`stb`=0, `done`=1 for one cycle, then IDLE. `cmd_ready`=0 in every state except IDLE.
- **Cycle type:**
  - `wb_cti_o`=000 when `cmd_len`=0.
  - Otherwise `wb_cti_o`=010 on non-last beats and 111 on the last beat.
  - `wb_bte_o`=00 (linear) always.
- **Read data:** `rd_valid`/`rd_data` are registered and appear the cycle after an ack that occurs while `wb_we_o`=0.
- **Reset values:** all bus outputs 0, `rd_valid`=0, `rd_data`=0, `done`=0, `status`=00, `wr_ready`=0, `cmd_ready`=1 (IDLE).
- **Reset mid-operation:** outputs return to reset values asynchronously, the command is discarded, and no `done` pulse is produced.

## Timing
- Command accepted in cycle 0. Reads: beat 0 is on the bus in cycle 1.
- With a zero-wait combinational-ack slave, a read issues one beat per cycle. The last `rd_valid` and `done` coincide at cycle `cmd_len`+2.
- Writes take 2 cycles per beat (WDATA then BUS) when `wr_valid` is held high; first `stb` is in cycle 2.
- Wait states extend BUS with all bus outputs held stable.
- Each rty costs 2 cycles: BACKOFF plus the reissue.

## Configuration
- **`WB_MASTER_TIMEOUT_EN` defined:**
  - A counter runs while in BUS with no termination and resets on any termination.
  - When it reaches `TIMEOUT_CYC`, the block aborts to DONE with `status`=11 and drops `cyc`.
- **Not defined:** BUS waits indefinitely and `status`=11 is never produced.

## Test plan
- Read, `cmd_len`=0, `adr`=0x100, slave acks combinationally with 0xDEADBEEF:
  - `cti`=000.
  - One `rd_valid` with 0xDEADBEEF.
  - `done` with `status`=00 at cycle 2.
- Read, `cmd_len`=3, `adr`=0x1FC:
  - Addresses 0x1FC, 0x200, 0x204, 0x208.
  - `cti` 010, 010, 010, 111.
  - Four consecutive `rd_valid`.
  - `done` at cycle 5.
- Write, `cmd_len`=1, `sel`=0xF, data 0x11111111 then 0x22222222, `wr_valid` held high:
  - Two `we`=1 beats at `adr` and `adr`+4 carrying that data.
  - `stb` in cycles 2 and 4.
  - `status`=00.
- Retry handling:
  - rty twice then ack: `cyc` low for 1 cycle after each rty, same address reissued, `status`=00.
  - rty five times with `RETRY_MAX`=4: `status`=10, no ack consumed.
- err on beat 2 of a `cmd_len`=3 read: exactly 2 `rd_valid`, `done` with `status`=01, no further `stb`.
- Timeout and reset:
  - With `WB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYC`=16, silent slave: `done` with `status`=11 after 16 `stb` cycles.
  - `rst` asserted mid-burst: `cyc`/`stb` drop in the same cycle and no `done` pulse.

Source files
------------

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: single-entry commands become classic or incrementing bursts.
// Define WB_MASTER_TIMEOUT_EN to enable the no-response watchdog (status 11).
module wb_burst_master #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int RETRY_MAX   = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [3:0]      cmd_len,
   input  logic [DW/8-1:0] cmd_sel,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [DW-1:0]   wr_data,
   output logic            rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic            done,
   output logic [1:0]      status,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_adr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i
);

   localparam int RW = $clog2(RETRY_MAX + 2);

   typedef enum logic [2:0] {
      IDLE, WDATA, BUS, BACKOFF, DONE
   } state_t;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic          len0, len0_n;
   logic [RW-1:0] rty_cnt;
   logic [1:0]    status_n;
   logic          accept, retry_out, to_hit;
   logic          term_ack, term_err, term_rty;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be positive");
   end

   assign accept    = (state == IDLE) & cmd_valid;
   assign term_err  = (state == BUS) & wb_err_i;
   assign term_rty  = (state == BUS) & wb_rty_i & ~wb_err_i;
   assign term_ack  = (state == BUS) & wb_ack_i & ~wb_err_i & ~wb_rty_i;
   assign retry_out = rty_cnt == RW'(RETRY_MAX);

   assign cmd_ready = state == IDLE;
   assign wr_ready  = state == WDATA;
   assign done      = state == DONE;
   assign wb_bte_o  = 2'b00;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
   logic          silent;

   assign silent = (state == BUS) & ~(wb_ack_i | wb_err_i | wb_rty_i);
   assign to_hit = silent & (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (silent)
         to_cnt <= to_cnt + TW'(1);
      else
         to_cnt <= '0;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      status_n = status;
      unique case (state)
         IDLE:
            if (cmd_valid) state_n = cmd_we ? WDATA : BUS;
         WDATA:
            if (wr_valid) state_n = BUS;
         BUS: begin
            if (term_err) begin
               state_n  = DONE;
               status_n = 2'b01;
            end else if (term_rty) begin
               if (retry_out) begin
                  state_n  = DONE;
                  status_n = 2'b10;
               end else begin
                  state_n = BACKOFF;
               end
            end else if (term_ack) begin
               if (cnt == 4'd0) begin
                  state_n  = DONE;
                  status_n = 2'b00;
               end else begin
                  state_n = wb_we_o ? WDATA : BUS;
               end
            end else if (to_hit) begin
               state_n  = DONE;
               status_n = 2'b11;
            end
         end
         BACKOFF: state_n = BUS;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign cnt_n  = accept ? cmd_len :
                   (term_ack && cnt != 4'd0) ? cnt - 4'd1 : cnt;
   assign len0_n = accept ? (cmd_len == 4'd0) : len0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         len0     <= 1'b0;
         rty_cnt  <= '0;
         status   <= 2'b00;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wb_cti_o <= 3'b000;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         cnt    <= cnt_n;
         len0   <= len0_n;
         status <= status_n;
         // cyc stays up across WDATA only when a burst is already running
         wb_cyc_o <= (state_n == BUS) |
                     ((state_n == WDATA) & (state == BUS));
         wb_stb_o <= state_n == BUS;
         wb_cti_o <= len0_n ? 3'b000 :
                     (cnt_n == 4'd0) ? 3'b111 : 3'b010;
         if (accept) begin
            wb_we_o  <= cmd_we;
            wb_sel_o <= cmd_sel;
            wb_adr_o <= cmd_adr & ~AW'(3);
         end else if (term_ack) begin
            wb_adr_o <= wb_adr_o + AW'(4);
         end
         if (state == WDATA && wr_valid)
            wb_dat_o <= wr_data;
         if (accept | term_ack)
            rty_cnt <= '0;
         else if (term_rty & ~retry_out)
            rty_cnt <= rty_cnt + RW'(1);
         rd_valid <= term_ack & ~wb_we_o;
         if (term_ack & ~wb_we_o)
            rd_data <= wb_dat_i;
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a scripted Wishbone slave.
module tb_wb_burst_master;

   localparam logic [1:0] NO = 2'd0, ACK = 2'd1, ERR = 2'd2, RTY = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [3:0]  cmd_len;
   logic [3:0]  cmd_sel;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;
   logic [1:0]  status;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;

   always #5 clk = ~clk;

   wb_burst_master #(.AW(32), .DW(32), .RETRY_MAX(4), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .done(done), .status(status),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   // scripted slave: resp[k] terminates the k-th strobed cycle
   logic [1:0]  resp [0:31];
   logic [31:0] wdat [0:3];
   int          k, wr_idx, cyc_no;
   logic        clr = 1'b0;
   logic [1:0]  r;
   logic        act;

   function automatic logic [31:0] rdat(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
   endfunction

   assign act      = wb_cyc_o & wb_stb_o;
   assign r        = (k < 32) ? resp[k] : NO;
   assign wb_ack_i = act & (r == ACK);
   assign wb_err_i = act & (r == ERR);
   assign wb_rty_i = act & (r == RTY);
   assign wb_dat_i = rdat(wb_adr_o);
   assign wr_data  = wdat[wr_idx[1:0]];

   always @(posedge clk) begin
      if (clr) begin
         k      <= 0;
         wr_idx <= 0;
         cyc_no <= 0;
      end else begin
         if (act) k <= k + 1;
         if (wr_valid & wr_ready) wr_idx <= wr_idx + 1;
         cyc_no <= cyc_no + 1;
      end
   end

   logic [31:0] stb_adr[$], ack_adr[$], ack_cti[$];
   logic [31:0] ack_dat[$], ack_cyc[$], rd_dat[$], rd_cyc[$];
   int          stb_cnt, ack_cnt, done_cnt, done_cyc;
   logic [1:0]  done_st;
   logic        cyc_log [0:63];

   always @(negedge clk) begin
      if (clr) begin
         stb_adr.delete(); ack_adr.delete(); ack_cti.delete();
         ack_dat.delete(); ack_cyc.delete();
         rd_dat.delete();  rd_cyc.delete();
         stb_cnt = 0; ack_cnt = 0; done_cnt = 0; done_cyc = -1;
         done_st = 2'b00;
         for (int i = 0; i < 64; i++) cyc_log[i] = 1'b0;
      end else begin
         if (cyc_no < 64) cyc_log[cyc_no] = wb_cyc_o;
         if (act) begin
            stb_cnt++;
            stb_adr.push_back(wb_adr_o);
            if (wb_ack_i && !wb_err_i && !wb_rty_i) begin
               ack_cnt++;
               ack_adr.push_back(wb_adr_o);
               ack_cti.push_back(32'(wb_cti_o));
               ack_dat.push_back(wb_dat_o);
               ack_cyc.push_back(32'(cyc_no));
            end
         end
         if (rd_valid) begin
            rd_dat.push_back(rd_data);
            rd_cyc.push_back(32'(cyc_no));
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc_no;
            done_st  = status;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hBAD0BAD0;
   endfunction

   task automatic fill(input logic [1:0] d);
      for (int i = 0; i < 32; i++) resp[i] = d;
   endtask

   task automatic start(input logic we, input logic [31:0] adr,
                        input logic [3:0] len);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input int lim);
      int i = 0;
      while (done_cnt == 0 && i < lim) begin
         @(posedge clk); #2;
         i++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
      cmd_sel = 4'hF; wr_valid = 1'b1;
      wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
      wdat[2] = 32'h33333333; wdat[3] = 32'h44444444;
      fill(ACK);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_we", wb_we_o, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_sel", wb_sel_o, 0);
      chk("rst_cti", wb_cti_o, 0);
      chk("rst_bte", wb_bte_o, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;

      // single read
      fill(ACK);
      start(1'b0, 32'h100, 4'd0);
      finish_cmd(100);
      chk("r1_done_n", done_cnt, 1);
      chk("r1_done_cyc", done_cyc, 2);
      chk("r1_status", done_st, 0);
      chk("r1_cti", at(ack_cti, 0), 0);
      chk("r1_rd_n", rd_dat.size(), 1);
      chk("r1_rd_dat", at(rd_dat, 0), 32'hDEADBEEF);
      chk("r1_rd_cyc", at(rd_cyc, 0), 2);

      // 4-beat read burst crossing 0x200
      start(1'b0, 32'h1FE, 4'd3);
      finish_cmd(100);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("r4_adr%0d", i), at(ack_adr, i), 32'h1FC + 32'(4 * i));
         chk($sformatf("r4_cti%0d", i), at(ack_cti, i), (i == 3) ? 7 : 2);
         chk($sformatf("r4_rdc%0d", i), at(rd_cyc, i), 32'(2 + i));
         chk($sformatf("r4_rdd%0d", i), at(rd_dat, i),
             rdat(32'h1FC + 32'(4 * i)));
      end
      chk("r4_rd_n", rd_dat.size(), 4);
      chk("r4_done_cyc", done_cyc, 5);
      chk("r4_status", done_st, 0);

      // 2-beat write burst
      start(1'b1, 32'h40, 4'd1);
      finish_cmd(100);
      chk("w2_adr0", at(ack_adr, 0), 32'h40);
      chk("w2_adr1", at(ack_adr, 1), 32'h44);
      chk("w2_dat0", at(ack_dat, 0), 32'h11111111);
      chk("w2_dat1", at(ack_dat, 1), 32'h22222222);
      chk("w2_stb0_cyc", at(ack_cyc, 0), 2);
      chk("w2_stb1_cyc", at(ack_cyc, 1), 4);
      chk("w2_cyc_hold", cyc_log[3], 1);
      chk("w2_stb_n", stb_cnt, 2);
      chk("w2_we", wb_we_o, 1);
      chk("w2_sel", wb_sel_o, 4'hF);
      chk("w2_rd_n", rd_dat.size(), 0);
      chk("w2_status", done_st, 0);
      chk("w2_done_cyc", done_cyc, 5);

      // two retries then ack
      fill(ACK); resp[0] = RTY; resp[1] = RTY;
      start(1'b0, 32'h80, 4'd0);
      finish_cmd(100);
      chk("rt_backoff1", cyc_log[2], 0);
      chk("rt_backoff2", cyc_log[4], 0);
      chk("rt_stb_n", stb_cnt, 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("rt_adr%0d", i), at(stb_adr, i), 32'h80);
      chk("rt_status", done_st, 0);
      chk("rt_done_cyc", done_cyc, 6);
      chk("rt_rd_dat", at(rd_dat, 0), rdat(32'h80));

      // retries exhausted
      fill(ACK);
      for (int i = 0; i < 5; i++) resp[i] = RTY;
      start(1'b0, 32'h84, 4'd0);
      finish_cmd(100);
      chk("rx_stb_n", stb_cnt, 5);
      chk("rx_ack_n", ack_cnt, 0);
      chk("rx_rd_n", rd_dat.size(), 0);
      chk("rx_status", done_st, 2);
      chk("rx_done_cyc", done_cyc, 10);

      // error on third beat
      fill(ACK); resp[2] = ERR;
      start(1'b0, 32'h300, 4'd3);
      finish_cmd(100);
      chk("er_rd_n", rd_dat.size(), 2);
      chk("er_stb_n", stb_cnt, 3);
      chk("er_status", done_st, 1);
      chk("er_done_n", done_cnt, 1);
      chk("er_done_cyc", done_cyc, 4);

      // wait states hold the address
      fill(ACK); resp[0] = NO; resp[1] = NO;
      start(1'b0, 32'h10, 4'd1);
      finish_cmd(100);
      chk("ws_adr0", at(stb_adr, 0), 32'h10);
      chk("ws_adr2", at(stb_adr, 2), 32'h10);
      chk("ws_adr3", at(stb_adr, 3), 32'h14);
      chk("ws_ack_cyc0", at(ack_cyc, 0), 3);
      chk("ws_ack_cyc1", at(ack_cyc, 1), 4);
      chk("ws_done_cyc", done_cyc, 5);

`ifdef WB_MASTER_TIMEOUT_EN
      fill(NO);
      start(1'b0, 32'h20, 4'd0);
      finish_cmd(100);
      chk("to_stb_n", stb_cnt, 16);
      chk("to_status", done_st, 3);
      chk("to_done_cyc", done_cyc, 17);
      chk("to_cyc_low", wb_cyc_o, 0);
`endif

      // reset mid-burst
      fill(NO); resp[0] = ACK;
      start(1'b0, 32'h500, 4'd3);
      repeat (3) @(posedge clk);
      #3;
      chk("mr_pre_cyc", wb_cyc_o, 1);
      #1 rst = 1'b1;
      #1;
      chk("mr_cyc", wb_cyc_o, 0);
      chk("mr_stb", wb_stb_o, 0);
      chk("mr_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("mr_done_n", done_cnt, 0);
      chk("mr_status", status, 0);
      chk("mr_idle", cmd_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
